// File: rtl/double_buffer_ctrl.sv
// Ping-pong bank controller for the ifmap/weight double buffers: tracks fill/read banks,
// generates wrapping per-bank addresses and holds each read bank for a programmable number of passes.
module double_buffer_ctrl #(
    parameter int ADDR_WID = 8,
    parameter int PASS_WID = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic [ADDR_WID-1:0] config_DEPTH,
    input  logic [PASS_WID-1:0] config_NUM_PASSES,
    input  logic                wr_valid,
    output logic                wr_ready,
    output logic                wr_en,
    output logic                wr_bank,
    output logic [ADDR_WID-1:0] wr_addr,
    output logic                rd_valid,
    input  logic                rd_en,
    output logic                rd_bank,
    output logic [ADDR_WID-1:0] rd_addr,
    output logic                bank_released
);

    localparam logic [ADDR_WID-1:0] ADDR_ONE = ADDR_WID'(1);
    localparam logic [PASS_WID-1:0] PASS_ONE = PASS_WID'(1);

    logic [1:0]          full_r;
    logic                wb_r;
    logic                rb_r;
    logic [ADDR_WID-1:0] wr_cnt_r;
    logic [ADDR_WID-1:0] rd_cnt_r;
    logic [PASS_WID-1:0] pass_cnt_r;
    logic                bank_released_r;

    logic [ADDR_WID-1:0] depth_last_s;
    logic [PASS_WID-1:0] pass_last_s;
    logic                wr_fire_s;
    logic                rd_fire_s;
    logic                wr_done_s;
    logic                pass_end_s;
    logic                release_s;
    logic [1:0]          full_nxt_s;

    // Handshake decode and end-of-bank / end-of-pass detection.
    always_comb begin
        depth_last_s = config_DEPTH - ADDR_ONE;
        pass_last_s  = {PASS_WID{1'b0}};
        full_nxt_s   = full_r;

        // A pass count of zero behaves as a single pass.
        if (config_NUM_PASSES == {PASS_WID{1'b0}}) begin
            pass_last_s = {PASS_WID{1'b0}};
        end else begin
            pass_last_s = config_NUM_PASSES - PASS_ONE;
        end

        wr_fire_s  = wr_valid & ~full_r[wb_r];
        rd_fire_s  = rd_en & full_r[rb_r];
        // >= rather than == so an out-of-contract depth change cannot strand a counter
        wr_done_s  = wr_fire_s & (wr_cnt_r >= depth_last_s);
        pass_end_s = rd_fire_s & (rd_cnt_r >= depth_last_s);
        release_s  = pass_end_s & (pass_cnt_r >= pass_last_s);

        // Fill and release always hit different banks: one needs full=0, the other full=1.
        if (wr_done_s) begin
            full_nxt_s[wb_r] = 1'b1;
        end else begin
            full_nxt_s[wb_r] = full_r[wb_r];
        end
        if (release_s) begin
            full_nxt_s[rb_r] = 1'b0;
        end else begin
            full_nxt_s[rb_r] = full_nxt_s[rb_r];
        end
    end

    // Bank state, address counters, pass counter and release pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_r          <= 2'b00;
            wb_r            <= 1'b0;
            rb_r            <= 1'b0;
            wr_cnt_r        <= {ADDR_WID{1'b0}};
            rd_cnt_r        <= {ADDR_WID{1'b0}};
            pass_cnt_r      <= {PASS_WID{1'b0}};
            bank_released_r <= 1'b0;
        end else if (clr) begin
            full_r          <= 2'b00;
            wb_r            <= 1'b0;
            rb_r            <= 1'b0;
            wr_cnt_r        <= {ADDR_WID{1'b0}};
            rd_cnt_r        <= {ADDR_WID{1'b0}};
            pass_cnt_r      <= {PASS_WID{1'b0}};
            bank_released_r <= 1'b0;
        end else begin
            full_r          <= full_nxt_s;
            bank_released_r <= release_s;

            if (wr_done_s) begin
                wr_cnt_r <= {ADDR_WID{1'b0}};
                wb_r     <= ~wb_r;
            end else if (wr_fire_s) begin
                wr_cnt_r <= wr_cnt_r + ADDR_ONE;
            end else begin
                wr_cnt_r <= wr_cnt_r;
            end

            if (pass_end_s) begin
                rd_cnt_r <= {ADDR_WID{1'b0}};
            end else if (rd_fire_s) begin
                rd_cnt_r <= rd_cnt_r + ADDR_ONE;
            end else begin
                rd_cnt_r <= rd_cnt_r;
            end

            if (release_s) begin
                pass_cnt_r <= {PASS_WID{1'b0}};
                rb_r       <= ~rb_r;
            end else if (pass_end_s) begin
                pass_cnt_r <= pass_cnt_r + PASS_ONE;
            end else begin
                pass_cnt_r <= pass_cnt_r;
            end
        end
    end

    assign wr_ready      = ~full_r[wb_r];
    assign wr_en         = wr_fire_s;
    assign wr_bank       = wb_r;
    assign wr_addr       = wr_cnt_r;
    assign rd_valid      = full_r[rb_r];
    assign rd_bank       = rb_r;
    assign rd_addr       = rd_cnt_r;
    assign bank_released = bank_released_r;

endmodule

// File: doc/double_buffer_ctrl.md
Name: double_buffer_ctrl

Overview:
- Ping-pong controller for the ifmap/weight double buffers in the CNN accelerator datapath.
- Sits between the upstream producer (off-chip loader) and downstream consumer (PE array feeder); tracks which bank is being filled and which is being read.
- Generates write/read bank addresses with internal wrapping counters sized by a runtime depth.
- Holds each read bank for a programmable number of read passes (data reuse) before releasing it back to the writer.

Parameters:
ADDR_WID, 8, width of per-bank address and of config_DEPTH
PASS_WID, 8, width of config_NUM_PASSES and internal pass counter

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous active-high reset
clr  input  1  synchronous clear; same state effect as rst, next edge
config_DEPTH  input  ADDR_WID  entries per bank; legal 1..2^ADDR_WID-1
config_NUM_PASSES  input  PASS_WID  full reads of a bank before release; 0 treated as 1
wr_valid  input  1  producer has an entry to write
wr_ready  output  1  write bank has space
wr_en  output  1  write strobe to buffer, = wr_valid & wr_ready
wr_bank  output  1  bank index being written
wr_addr  output  ADDR_WID  address within wr_bank
rd_valid  output  1  read bank full and readable
rd_en  input  1  consumer reads entry this cycle
rd_bank  output  1  bank index being read
rd_addr  output  ADDR_WID  address within rd_bank
bank_released  output  1  one-cycle pulse, registered, after a read bank is freed

Behaviour:
- State: full[1:0], wb, rb, wr_cnt, rd_cnt (ADDR_WID), pass_cnt (PASS_WID), bank_released reg.
- Reset (rst high, async) or clr (sync): full=00, wb=rb=0, wr_cnt=rd_cnt=pass_cnt=0, bank_released=0.
- Hence after reset: wr_ready=1, rd_valid=0, wr_addr=rd_addr=0, wr_bank=rd_bank=0.
- rst takes priority over clr.
- Combinational outputs:
  - wr_ready = ~full[wb]; wr_addr = wr_cnt; wr_bank = wb.
  - rd_valid = full[rb]; rd_addr = rd_cnt; rd_bank = rb.
- Write handshake (wr_valid & wr_ready):
  - If wr_cnt == config_DEPTH-1: wr_cnt<=0, full[wb]<=1, wb<=~wb.
  - Otherwise wr_cnt<=wr_cnt+1.
  - wr_valid while wr_ready=0: no state change, wr_en=0.
- Read (rd_en & rd_valid):
  - If rd_cnt != config_DEPTH-1: rd_cnt<=rd_cnt+1.
  - Else rd_cnt<=0, and:
    - If pass_cnt == max(config_NUM_PASSES,1)-1: pass_cnt<=0, full[rb]<=0, rb<=~rb, bank_released<=1.
    - Otherwise pass_cnt<=pass_cnt+1.
  - rd_en while rd_valid=0: ignored, no state change.
- bank_released is 0 on every cycle it is not set as above.
- Latency:
  - Last write on edge N → rd_valid high in cycle after N if rb==that bank.
  - Release on edge M → wr_ready high after M if writer was stalled on that bank.
- Simultaneous write-complete and read-release in the same cycle: both apply.
  - They can never target the same bank, since write needs full=0 and release needs full=1.
- Both banks full: wr_ready=0 until a release. Both empty: rd_valid=0.
- config_DEPTH=1: every accepted write fills a bank; every read is end of pass.
- Config inputs must be held stable between clr/reset and the layer's last release.
- Config changes mid-layer are outside contract; RTL must not lock up — it resumes correctly after clr.
- Async rst asserted mid-transfer: all state returns to reset values immediately; no partial bank is kept.

Test Plan:
- DEPTH=4, PASSES=1, write 4 entries back-to-back → wr_addr 0,1,2,3 on bank 0; rd_valid=1 next cycle, rd_bank=0, wr_bank=1, wr_ready=1.
- DEPTH=4, PASSES=3, bank 0 full, rd_en held high → rd_addr cycles 0..3 three times (12 reads); full[0] clears after 12th read; bank_released pulses exactly one cycle later; rd_bank=1.
- DEPTH=3, PASSES=1, write 6 entries with no reads → wr_ready=0 after 6th write; extra wr_valid for 5 cycles gives wr_en=0; one full read of bank 0 → wr_ready=1, wr_bank=0, wr_addr=0.
- Streaming, DEPTH=2, PASSES=1 → write completing bank 1 on the same edge that bank 0 is released: full=10, wb=0, rb=1, no lost entry (checked by scoreboard on 20 random-stall entries).
- rd_en asserted while rd_valid=0, and config_NUM_PASSES=0 → no counter movement; bank released after one pass.
- rst pulsed asynchronously mid-write (wr_cnt=2) and clr mid-read → all outputs at reset values (wr_ready=1, rd_valid=0, addrs 0); clean refill succeeds.
